mips_control: RTL and testbench
===============================

MIPS_CONTROL -- requirements
Module: mips_control

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 opCode  input  6  instruction bits [31:26].
REQ-005 rtype, lw, sw, j, beq  output  1 each  registered instruction-class flags.
REQ-006 RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite  output  1 each  registered datapath controls.
REQ-007 ALUop  output  2  registered ALU class: bit1 = rtype, bit0 = beq.

Function
REQ-008 Class decode from opCode:
- rtype = (opCode == 6'b000000)
- lw = 6'b100011 (35)
- sw = 6'b101011 (43)
- j = 6'b000010 (2)
- beq = 6'b000100 (4)
REQ-009 At most one class flag SHALL be 1. Any other opcode (e.g. addi = 8) SHALL give all five flags 0.
REQ-010 Control equations:
- RegDst = rtype
- ALUSrc = NOT(rtype OR beq)
- RegWrite = NOT(sw OR beq OR j)
- Mem2Reg = lw
- MemRead = lw
- MemWrite = sw
REQ-011 ALUop encoding: 2'b10 for R-type, 2'b01 for beq, 2'b00 otherwise. 2'b11 SHALL never be produced.
REQ-012 Unlisted opcodes SHALL decode as immediate ALU ops: RegWrite=1, ALUSrc=1, all other controls 0, ALUop=00.
REQ-013 The decode is combinational. All outputs SHALL be captured in one register stage, so latency is exactly 1 clk edge from opCode to outputs.
REQ-014 Outputs SHALL hold their value between edges, independent of opCode changes.
REQ-015 The module SHALL have no other state; each cycle's output depends only on opCode at the previous edge.
REQ-016 X/Z on opCode SHALL NOT be decoded specially; behaviour is the synthesised equations.

Reset
REQ-017 While rst=1 at a rising edge, all outputs SHALL become 0 (safe NOP: no register write, no memory access), regardless of opCode.
REQ-018 When rst is asserted mid-stream, its effect is visible after the next edge. Decoding SHALL resume on the first edge with rst=0.
REQ-019 rst SHALL have no asynchronous effect.

Structure
REQ-020 Opcode constants (RTYPE=0, J=2, BEQ=4, ADDI=8, LW=35, SW=43) and the ALUop encodings SHALL live in a shared package used by the ALU-control block.
REQ-021 The class decode SHALL be a single natural sub-module, opcode_decode (combinational, opCode -> five flags). The control equations, ALUop logic and output register SHALL live in mips_control.

Verification
REQ-022 rst=1 for 2 edges with opCode=0 -> all outputs 0. After rst=0 and one edge with opCode=0: rtype=1, RegDst=1, RegWrite=1, ALUSrc=0, ALUop=10.
REQ-023 opCode=35 -> after 1 edge: lw=1, ALUSrc=1, RegWrite=1, MemRead=1, Mem2Reg=1, MemWrite=0, ALUop=00.
REQ-024 opCode=43 -> sw=1, MemWrite=1, ALUSrc=1, RegWrite=0, MemRead=0.
REQ-025 opCode=4 -> beq=1, ALUop=01, ALUSrc=0, RegWrite=0. Then opCode=2 -> j=1, RegWrite=0, ALUSrc=1, ALUop=00.
REQ-026 opCode=8 -> all flags 0, RegWrite=1, ALUSrc=1, ALUop=00. Sweep all 64 opcodes and check that flags are one-hot-or-zero and outputs match REQ-010 against a reference model.
REQ-027 Change opCode between edges -> outputs stay unchanged until the next edge. Assert rst on a cycle with opCode=35 -> outputs 0 on that edge.

Source files
------------

// File: rtl/mips_control_pkg.sv
// Shared opcode constants, ALUop encodings and the registered control bundle
// for the single-cycle MIPS main control.
package mips_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       rtype;
        logic       lw;
        logic       sw;
        logic       j;
        logic       beq;
        logic       reg_dst;
        logic       alu_src;
        logic       reg_write;
        logic       mem2reg;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational instruction-class decode: opCode -> five mutually exclusive
// class flags; any unlisted opcode leaves all flags low.
module opcode_decode
    import mips_control_pkg::*;
(
    input  logic [5:0] i_op_code,
    output logic       o_rtype,
    output logic       o_lw,
    output logic       o_sw,
    output logic       o_j,
    output logic       o_beq
);

    assign o_rtype = (i_op_code == OP_RTYPE);
    assign o_lw    = (i_op_code == OP_LW);
    assign o_sw    = (i_op_code == OP_SW);
    assign o_j     = (i_op_code == OP_J);
    assign o_beq   = (i_op_code == OP_BEQ);

endmodule

// File: rtl/mips_control.sv
// MIPS main control: class decode, datapath control equations and ALUop,
// all captured in one register stage with synchronous active-high reset.
module mips_control
    import mips_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opCode,
    output logic       rtype,
    output logic       lw,
    output logic       sw,
    output logic       j,
    output logic       beq,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       Mem2Reg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] ALUop
);

    logic  w_rtype;
    logic  w_lw;
    logic  w_sw;
    logic  w_j;
    logic  w_beq;
    ctrl_t w_next;
    ctrl_t r_ctrl;

    opcode_decode u_opcode_decode (
        .i_op_code (opCode),
        .o_rtype   (w_rtype),
        .o_lw      (w_lw),
        .o_sw      (w_sw),
        .o_j       (w_j),
        .o_beq     (w_beq)
    );

    // Unlisted opcodes fall through as immediate ALU ops (RegWrite, ALUSrc).
    always_comb begin
        w_next           = '0;
        w_next.rtype     = w_rtype;
        w_next.lw        = w_lw;
        w_next.sw        = w_sw;
        w_next.j         = w_j;
        w_next.beq       = w_beq;
        w_next.reg_dst   = w_rtype;
        w_next.alu_src   = ~(w_rtype | w_beq);
        w_next.reg_write = ~(w_sw | w_beq | w_j);
        w_next.mem2reg   = w_lw;
        w_next.mem_read  = w_lw;
        w_next.mem_write = w_sw;
        if (w_rtype)
            w_next.alu_op = ALUOP_FUNCT;
        else if (w_beq)
            w_next.alu_op = ALUOP_SUB;
        else
            w_next.alu_op = ALUOP_ADD;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ctrl <= '0;
        else
            r_ctrl <= w_next;
    end

    assign rtype    = r_ctrl.rtype;
    assign lw       = r_ctrl.lw;
    assign sw       = r_ctrl.sw;
    assign j        = r_ctrl.j;
    assign beq      = r_ctrl.beq;
    assign RegDst   = r_ctrl.reg_dst;
    assign ALUSrc   = r_ctrl.alu_src;
    assign RegWrite = r_ctrl.reg_write;
    assign Mem2Reg  = r_ctrl.mem2reg;
    assign MemRead  = r_ctrl.mem_read;
    assign MemWrite = r_ctrl.mem_write;
    assign ALUop    = r_ctrl.alu_op;

endmodule

// File: tb/tb_mips_control.sv
// Self-checking bench for mips_control: directed cases, full opcode sweep and
// randomized opcode/reset stream against a per-instruction truth-table model.
module tb_mips_control;

    logic       clk;
    logic       rst;
    logic [5:0] opCode;
    logic       rtype, lw, sw, j, beq;
    logic       RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite;
    logic [1:0] ALUop;

    int n_checks = 0;
    int n_errors = 0;

    mips_control dut (
        .clk      (clk),
        .rst      (rst),
        .opCode   (opCode),
        .rtype    (rtype),
        .lw       (lw),
        .sw       (sw),
        .j        (j),
        .beq      (beq),
        .RegDst   (RegDst),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .Mem2Reg  (Mem2Reg),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ALUop    (ALUop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {rtype,lw,sw,j,beq, RegDst,ALUSrc,RegWrite,Mem2Reg,MemRead,MemWrite, ALUop}
    function automatic logic [12:0] model(input logic [5:0] op);
        case (op)
            6'd0:    return {5'b10000, 6'b101000, 2'b10};
            6'd35:   return {5'b01000, 6'b011110, 2'b00};
            6'd43:   return {5'b00100, 6'b010001, 2'b00};
            6'd2:    return {5'b00010, 6'b010000, 2'b00};
            6'd4:    return {5'b00001, 6'b000000, 2'b01};
            default: return {5'b00000, 6'b011000, 2'b00};
        endcase
    endfunction

    function automatic logic [12:0] observed();
        return {rtype, lw, sw, j, beq, RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite, ALUop};
    endfunction

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, let the edge happen, compare outputs.
    task automatic step(input string tag, input logic [5:0] op, input logic r);
        logic [12:0] exp;
        @(negedge clk);
        opCode = op;
        rst    = r;
        @(posedge clk);
        #1;
        exp = r ? 13'd0 : model(op);
        chk(tag, observed(), exp);
    endtask

    initial begin
        logic [12:0] held;
        logic [5:0]  op;
        logic        r;

        rst    = 1'b1;
        opCode = 6'd0;

        step("reset_edge1", 6'd0, 1'b1);
        step("reset_edge2", 6'd0, 1'b1);
        step("rtype",       6'd0, 1'b0);
        step("lw",          6'd35, 1'b0);
        step("sw",          6'd43, 1'b0);
        step("beq",         6'd4, 1'b0);
        step("j",           6'd2, 1'b0);
        step("addi",        6'd8, 1'b0);

        for (int k = 0; k < 64; k++) begin
            step($sformatf("sweep_op%0d", k), 6'(k), 1'b0);
            chk($sformatf("onehot_op%0d", k), 13'($countones({rtype, lw, sw, j, beq}) <= 1), 13'd1);
            chk($sformatf("aluop_not11_op%0d", k), 13'(ALUop == 2'b11), 13'd0);
        end

        // Outputs must hold while opCode changes between edges.
        step("hold_setup", 6'd35, 1'b0);
        held = model(6'd35);
        opCode = 6'd4;
        #1;
        chk("hold_beq", observed(), held);
        opCode = 6'd0;
        #2;
        chk("hold_rtype", observed(), held);

        // Reset mid-stream with lw pending, then resume.
        step("midrst_pre",  6'd43, 1'b0);
        step("midrst_lw",   6'd35, 1'b1);
        step("midrst_resume", 6'd35, 1'b0);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       op = 6'($urandom_range(0, 63));
                default: begin
                    case ($urandom_range(0, 5))
                        0: op = 6'd0;
                        1: op = 6'd35;
                        2: op = 6'd43;
                        3: op = 6'd2;
                        4: op = 6'd4;
                        default: op = 6'd8;
                    endcase
                end
            endcase
            r = ($urandom_range(0, 15) == 0);
            step($sformatf("rand%0d_op%0d_rst%0d", k, op, r), op, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
